// File: rtl/brightness_stepper_if.sv
// ROM read bus between brightness_stepper (master) and the duty-word ROM (slave).
//   rom_en   : one-cycle read strobe
//   rom_addr : level index to read
//   rom_data : read data, valid the cycle after rom_en
interface brightness_stepper_if #(
  parameter int unsigned AW = 4
);
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;

  modport master (output rom_en, output rom_addr, input rom_data);
  modport slave  (input rom_en, input rom_addr, output rom_data);
endinterface

// File: rtl/brightness_stepper.sv
// Brightness control stage ahead of the LED PWM generator.
// Debounces two active-low buttons and steps a saturating level index.
// Fetches the duty word for the level from a synchronous ROM.
// Commits the word to duty only at a PWM period boundary.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   btn_up_n, btn_dn_n   raw async buttons, low = pressed
//   rom                  ROM read bus (master side)
//   duty                 committed duty word, clamped to PERIOD
//   level                current level index
//   period_end           pulse on the last cycle of each PWM period
//   busy                 high from fetch start until commit; presses dropped
module brightness_stepper #(
  parameter int unsigned PERIOD       = 50000,
  parameter int unsigned LEVELS       = 16,
  parameter int unsigned AW           = 4,
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_up_n,
  input  logic                 btn_dn_n,
  brightness_stepper_if.master rom,
  output logic [15:0]          duty,
  output logic [AW-1:0]        level,
  output logic                 period_end,
  output logic                 busy
);

  localparam int unsigned CW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned DCW = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t         state;
  logic [15:0]    pending;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt_c;

  // Index 0 = up button, index 1 = down button.
  logic [1:0]     btn_raw_c;
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     deb;
  logic [1:0]     press;
  logic [DCW-1:0] dcnt [2];

  assign btn_raw_c = {btn_dn_n, btn_up_n};

  // Synchronise, debounce, and emit a one-cycle press pulse on debounced high->low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      deb     <= 2'b11;
      press   <= 2'b00;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      sync1 <= btn_raw_c;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DCW'(DEBOUNCE_CYC - 1)) begin
          // This is the DEBOUNCE_CYC-th consecutive differing sample.
          deb[i]   <= sync2[i];
          dcnt[i]  <= '0;
          press[i] <= ~sync2[i];
        end else begin
          dcnt[i] <= dcnt[i] + DCW'(1);
        end
      end
    end
  end

  // Free-running PWM period counter.
  always_comb begin
    cnt_nxt_c = (cnt == CW'(PERIOD - 1)) ? '0 : cnt + CW'(1);
  end

  // period_end is registered from the next count so it is high exactly while cnt == PERIOD-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      period_end <= 1'b0;
    end else begin
      cnt        <= cnt_nxt_c;
      period_end <= (cnt_nxt_c == CW'(PERIOD - 1));
    end
  end

  // Level/fetch/commit FSM. rom_en is high for the first WAIT cycle; the ROM
  // answers in the second WAIT cycle, recognised by rom_en having dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      level        <= '0;
      duty         <= '0;
      pending      <= '0;
      busy         <= 1'b1;
      rom.rom_en   <= 1'b0;
      rom.rom_addr <= '0;
    end else begin
      rom.rom_en <= 1'b0;
      case (state)
        S_IDLE: begin
          // Simultaneous up and down events cancel out.
          if (press[0] && !press[1] && (level != AW'(LEVELS - 1))) begin
            level <= level + AW'(1);
            busy  <= 1'b1;
            state <= S_FETCH;
          end else if (press[1] && !press[0] && (level != '0)) begin
            level <= level - AW'(1);
            busy  <= 1'b1;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          rom.rom_en   <= 1'b1;
          rom.rom_addr <= level;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (!rom.rom_en) begin
            pending <= (32'(rom.rom_data) > 32'(PERIOD)) ? 16'(PERIOD) : rom.rom_data;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Commit on the last cycle of a period so the new word starts a fresh period.
          if (period_end) begin
            duty  <= pending;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brightness_stepper.sv
// Directed bench for brightness_stepper with PERIOD=20, DEBOUNCE_CYC=4,
// LEVELS=4 and ROM contents {0,5,12,30}.
module tb_brightness_stepper;

  localparam int unsigned PERIOD = 20;
  localparam int unsigned LEVELS = 4;
  localparam int unsigned AW     = 2;
  localparam int unsigned DEB    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_up_n = 1'b1;
  logic          btn_dn_n = 1'b1;
  logic [15:0]   duty;
  logic [AW-1:0] level;
  logic          period_end;
  logic          busy;

  brightness_stepper_if #(.AW(AW)) bus ();

  brightness_stepper #(
    .PERIOD(PERIOD),
    .LEVELS(LEVELS),
    .AW(AW),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_up_n(btn_up_n),
    .btn_dn_n(btn_dn_n),
    .rom(bus),
    .duty(duty),
    .level(level),
    .period_end(period_end),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid the cycle after rom_en.
  logic [15:0] rom_tbl [LEVELS];
  initial rom_tbl = '{16'd0, 16'd5, 16'd12, 16'd30};
  always @(posedge clk) if (bus.rom_en) bus.rom_data <= rom_tbl[bus.rom_addr];

  // Count ROM reads and remember the last address.
  int            rom_cnt = 0;
  logic [AW-1:0] rom_last = '0;
  always @(posedge clk) begin
    if (bus.rom_en) begin
      rom_cnt  = rom_cnt + 1;
      rom_last = bus.rom_addr;
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic        pe_last = 1'b0;
  logic [15:0] duty_last = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for busy to drop, remembering period_end/duty from the last busy sample.
  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      pe_last   = period_end;
      duty_last = duty;
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_pe(input int budget);
    int n = 0;
    while (!period_end && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("pe_seen", 32'(period_end), 32'd1);
  endtask

  task automatic press(input bit up, input bit dn, input int hold, input int rel);
    if (up) btn_up_n = 1'b0;
    if (dn) btn_dn_n = 1'b0;
    cyc(hold);
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    cyc(rel);
  endtask

  int exp_lvl  [4] = '{1, 2, 3, 3};
  int exp_duty [4] = '{5, 12, 20, 20};
  int exp_rd   [4] = '{1, 1, 1, 0};

  initial begin
    int r0;

    // Reset values.
    cyc(3);
    chk("rst_duty", 32'(duty), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_rom_en", 32'(bus.rom_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_pe", 32'(period_end), 32'd0);

    // Post-reset fetch of level 0, commit at the first period_end.
    rst_n = 1'b1;
    cyc(1);
    chk("boot_rom_en", 32'(bus.rom_en), 32'd1);
    chk("boot_rom_addr", 32'(bus.rom_addr), 32'd0);
    cyc(1);
    chk("boot_rom_en_off", 32'(bus.rom_en), 32'd0);
    cyc(17);
    chk("boot_busy_pre", 32'(busy), 32'd1);
    chk("boot_pe", 32'(period_end), 32'd1);
    cyc(1);
    chk("boot_busy_post", 32'(busy), 32'd0);
    chk("boot_duty", 32'(duty), 32'd0);
    chk("boot_pe_off", 32'(period_end), 32'd0);
    chk("boot_rom_cnt", 32'(rom_cnt), 32'd1);

    // Up held 10 cycles -> level 1, duty 5 committed at a period boundary.
    r0 = rom_cnt;
    btn_up_n = 1'b0;
    cyc(10);
    btn_up_n = 1'b1;
    chk("up_busy", 32'(busy), 32'd1);
    chk("up_level", 32'(level), 32'd1);
    wait_idle(60, "up");
    chk("up_commit_at_pe", 32'(pe_last), 32'd1);
    chk("up_duty_before", 32'(duty_last), 32'd0);
    chk("up_duty", 32'(duty), 32'd5);
    chk("up_rom_reads", 32'(rom_cnt - r0), 32'd1);
    chk("up_rom_addr", 32'(rom_last), 32'd1);
    cyc(10);

    // Three-cycle glitch -> no event.
    r0 = rom_cnt;
    press(1'b1, 1'b0, 3, 30);
    chk("glitch_level", 32'(level), 32'd1);
    chk("glitch_rom_reads", 32'(rom_cnt - r0), 32'd0);
    chk("glitch_duty", 32'(duty), 32'd5);
    chk("glitch_busy", 32'(busy), 32'd0);

    // Restart from level 0, then four up presses saturate at level 3.
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    wait_idle(60, "rst2");
    chk("rst2_duty", 32'(duty), 32'd0);
    chk("rst2_level", 32'(level), 32'd0);
    for (int i = 0; i < 4; i++) begin
      r0 = rom_cnt;
      press(1'b1, 1'b0, 8, 8);
      wait_idle(60, "sat");
      chk($sformatf("sat%0d_level", i), 32'(level), 32'(exp_lvl[i]));
      chk($sformatf("sat%0d_duty", i), 32'(duty), 32'(exp_duty[i]));
      chk($sformatf("sat%0d_rom_reads", i), 32'(rom_cnt - r0), 32'(exp_rd[i]));
    end

    // Up and down together -> ignored.
    r0 = rom_cnt;
    press(1'b1, 1'b1, 8, 8);
    chk("both_level", 32'(level), 32'd3);
    chk("both_rom_reads", 32'(rom_cnt - r0), 32'd0);
    chk("both_busy", 32'(busy), 32'd0);
    chk("both_duty", 32'(duty), 32'd20);

    // Down alone -> level 2.
    press(1'b0, 1'b1, 8, 8);
    wait_idle(60, "dn");
    chk("dn_level", 32'(level), 32'd2);
    chk("dn_duty", 32'(duty), 32'd12);

    // Up right after a period boundary; down event lands while busy and is dropped.
    wait_pe(40);
    r0 = rom_cnt;
    btn_up_n = 1'b0;
    cyc(4);
    btn_dn_n = 1'b0;
    cyc(8);
    chk("drop_busy", 32'(busy), 32'd1);
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    wait_idle(60, "drop");
    chk("drop_level", 32'(level), 32'd3);
    chk("drop_duty", 32'(duty), 32'd20);
    chk("drop_rom_reads", 32'(rom_cnt - r0), 32'd1);
    cyc(10);

    // Reset while holding the fetched word for level 2.
    wait_pe(40);
    btn_dn_n = 1'b0;
    cyc(8);
    btn_dn_n = 1'b1;
    cyc(4);
    chk("hold_level", 32'(level), 32'd2);
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_duty", 32'(duty), 32'd20);
    rst_n = 1'b0;
    #1;
    chk("midrst_duty", 32'(duty), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_rom_en", 32'(bus.rom_en), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    r0 = rom_cnt;
    cyc(1);
    chk("refetch_rom_en", 32'(bus.rom_en), 32'd1);
    chk("refetch_rom_addr", 32'(bus.rom_addr), 32'd0);
    wait_idle(60, "refetch");
    chk("refetch_duty", 32'(duty), 32'd0);
    chk("refetch_level", 32'(level), 32'd0);
    chk("refetch_rom_reads", 32'(rom_cnt - r0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
